stage3_execute_wb: RTL

Stage 3 (execute/writeback) of the three-stage pipelined processor. It consumes decoded operations from the stage-2 pipeline register and performs them: single-cycle ALU ops and serial one-bit-per-cycle shifts. It drives the one-hot load lines and shared data bus back to registers R0–R5, and drives the processor's `output_bus`/`valid_output`. It back-pressures stage 2 with `in_ready` while a multi-cycle shift is in progress.

---
 rtl/stage3_execute_wb.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/stage3_execute_wb.sv
// Execute/writeback stage: single-cycle ALU ops plus serial one-bit-per-cycle
// shifts, driving one-hot register loads, the output port and the flag register.
module stage3_execute_wb #(
    parameter int N  = 32,
    parameter int SW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_op,
    input  logic [N-1:0]  in_a,
    input  logic [N-1:0]  in_b,
    input  logic [SW-1:0] in_shamt,
    input  logic [2:0]    in_dst,
    output logic [N-1:0]  wb_data,
    output logic [5:0]    wb_load,
    output logic [N-1:0]  output_bus,
    output logic          valid_output,
    output logic [3:0]    flags,
    output logic          busy
);
    localparam int CW = $clog2(N + 1);

    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_NOT = 4'd6;
    localparam logic [3:0] OP_MOV = 4'd7;
    localparam logic [3:0] OP_INC = 4'd12;
    localparam logic [3:0] OP_DEC = 4'd13;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state_reg, state_next;
    logic [N-1:0]  sh_reg, sh_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [1:0]    sh_kind_reg, sh_kind_next;
    logic [2:0]    sh_dst_reg, sh_dst_next;

    logic [N-1:0]  wb_data_reg, wb_data_next;
    logic [5:0]    wb_load_reg, wb_load_next;
    logic [N-1:0]  output_bus_reg, output_bus_next;
    logic          valid_output_reg, valid_output_next;
    logic [3:0]    flags_reg, flags_next;

    logic          accept, is_alu, is_shift, sub_op;
    logic [N-1:0]  operand, eff_b, alu_res;
    logic [N:0]    sum;
    logic          alu_c, alu_v;
    logic [N:0]    step;
    logic [CW-1:0] shamt_sat;
    logic          fin_valid, fin_c, fin_v;
    logic [N-1:0]  fin_res;
    logic [2:0]    fin_dst;

    // One serial shift step; kind is the low two opcode bits (SLL, SRL, SRA, ROL).
    // Returns {bit shifted out, shifted value}.
    function automatic logic [N:0] shift_step(input logic [1:0] kind, input logic [N-1:0] v);
        logic [N:0] r;
        case (kind)
            2'd0:    r = {v[N-1], v[N-2:0], 1'b0};
            2'd1:    r = {v[0], 1'b0, v[N-1:1]};
            2'd2:    r = {v[0], v[N-1], v[N-1:1]};
            default: r = {v[N-1], v[N-2:0], v[N-1]};
        endcase
        return r;
    endfunction

    assign accept   = in_valid && in_ready;
    assign is_shift = (in_op >= 4'd8) && (in_op <= 4'd11);
    assign is_alu   = ((in_op >= OP_ADD) && (in_op <= OP_MOV)) || (in_op == OP_INC) || (in_op == OP_DEC);
    assign step     = shift_step(sh_kind_reg, sh_reg);

    always_comb begin
        shamt_sat = (int'(in_shamt) > N) ? CW'(N) : CW'(int'(in_shamt));
    end

    // Subtraction is A + ~B + 1, so the carry out is the inverse of the borrow.
    always_comb begin
        sub_op  = (in_op == OP_SUB) || (in_op == OP_DEC);
        operand = ((in_op == OP_INC) || (in_op == OP_DEC)) ? {{(N-1){1'b0}}, 1'b1} : in_b;
        eff_b   = sub_op ? ~operand : operand;
        sum     = {1'b0, in_a} + {1'b0, eff_b} + {{N{1'b0}}, sub_op};
        alu_res = in_a;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (in_op)
            OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
                alu_res = sum[N-1:0];
                alu_c   = sub_op ? ~sum[N] : sum[N];
                alu_v   = (in_a[N-1] == eff_b[N-1]) && (sum[N-1] != in_a[N-1]);
            end
            OP_AND:  alu_res = in_a & in_b;
            OP_OR:   alu_res = in_a | in_b;
            OP_XOR:  alu_res = in_a ^ in_b;
            OP_NOT:  alu_res = ~in_a;
            OP_MOV:  alu_res = in_b;
            default: alu_res = in_a;
        endcase
    end

    always_comb begin
        state_next   = state_reg;
        sh_next      = sh_reg;
        cnt_next     = cnt_reg;
        sh_kind_next = sh_kind_reg;
        sh_dst_next  = sh_dst_reg;
        fin_valid    = 1'b0;
        fin_res      = alu_res;
        fin_c        = alu_c;
        fin_v        = alu_v;
        fin_dst      = in_dst;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (is_alu || (is_shift && (in_shamt == '0))) begin
                        fin_valid = 1'b1;
                    end else if (is_shift) begin
                        sh_next      = in_a;
                        cnt_next     = shamt_sat;
                        sh_kind_next = in_op[1:0];
                        sh_dst_next  = in_dst;
                        state_next   = SHIFT;
                    end
                end
            end
            SHIFT: begin
                sh_next  = step[N-1:0];
                cnt_next = cnt_reg - CW'(1);
                if (cnt_reg == CW'(1)) begin
                    fin_valid  = 1'b1;
                    fin_res    = step[N-1:0];
                    fin_c      = step[N];
                    fin_v      = 1'b0;
                    fin_dst    = sh_dst_reg;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        wb_data_next      = wb_data_reg;
        output_bus_next   = output_bus_reg;
        valid_output_next = 1'b0;
        flags_next        = flags_reg;
        if (fin_valid) begin
            wb_data_next = fin_res;
            flags_next   = {(fin_res == '0), fin_res[N-1], fin_c, fin_v};
            if (fin_dst == 3'd6) begin
                output_bus_next   = fin_res;
                valid_output_next = 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_load
            assign wb_load_next[gi] = fin_valid && (fin_dst == 3'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            sh_reg           <= '0;
            cnt_reg          <= '0;
            sh_kind_reg      <= '0;
            sh_dst_reg       <= '0;
            wb_data_reg      <= '0;
            wb_load_reg      <= '0;
            output_bus_reg   <= '0;
            valid_output_reg <= 1'b0;
            flags_reg        <= '0;
        end else begin
            state_reg        <= state_next;
            sh_reg           <= sh_next;
            cnt_reg          <= cnt_next;
            sh_kind_reg      <= sh_kind_next;
            sh_dst_reg       <= sh_dst_next;
            wb_data_reg      <= wb_data_next;
            wb_load_reg      <= wb_load_next;
            output_bus_reg   <= output_bus_next;
            valid_output_reg <= valid_output_next;
            flags_reg        <= flags_next;
        end
    end

    assign in_ready     = (state_reg == IDLE) && !reset;
    assign busy         = (state_reg == SHIFT);
    assign wb_data      = wb_data_reg;
    assign wb_load      = wb_load_reg;
    assign output_bus   = output_bus_reg;
    assign valid_output = valid_output_reg;
    assign flags        = flags_reg;

endmodule
